// File: rtl/l2_banked_cut_array.sv
// Word-interleaved multi-port SRAM cut array: per-bank round-robin arbitration, behavioural cuts
// with a configurable read latency, and a per-port return pipeline that remembers the serving cut.
module l2_banked_cut_array #(
  parameter int unsigned N_PORTS      = 2,
  parameter int unsigned N_BANKS      = 4,
  parameter int unsigned N_ROWS       = 2,
  parameter int unsigned CUT_DW       = 64,
  parameter int unsigned CUT_N_WORDS  = 16384,
  parameter int unsigned SRAM_LATENCY = 1,
  parameter int unsigned ADDR_WIDTH   = $clog2(N_BANKS * N_ROWS * CUT_N_WORDS),
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [N_PORTS-1:0]                 req_i,
  output logic [N_PORTS-1:0]                 gnt_o,
  input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [N_PORTS-1:0]                 we_i,
  input  logic [N_PORTS-1:0][CUT_DW-1:0]     wdata_i,
  input  logic [N_PORTS-1:0][CUT_DW/8-1:0]   be_i,
  output logic [N_PORTS-1:0]                 rvalid_o,
  output logic [N_PORTS-1:0][CUT_DW-1:0]     rdata_o,
  output logic [CNT_WIDTH-1:0]               conflict_cnt_o,
  input  logic                               conflict_clr_i
);

  localparam int unsigned BankBits = $clog2(N_BANKS);
  localparam int unsigned WordBits = $clog2(CUT_N_WORDS);
  localparam int unsigned BankW    = (N_BANKS > 1) ? BankBits : 1;
  localparam int unsigned RowW     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned WordW    = (CUT_N_WORDS > 1) ? WordBits : 1;
  localparam int unsigned PortW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned PortSumW = PortW + 1;
  localparam int unsigned BeW      = CUT_DW / 8;
  localparam int unsigned SumW     = CNT_WIDTH + 1;

  // Address decode per port
  logic [BankW-1:0] port_bank [N_PORTS];
  logic [RowW-1:0]  port_row  [N_PORTS];
  logic [WordW-1:0] port_word [N_PORTS];

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      port_bank[p] = BankW'(addr_i[p] & ADDR_WIDTH'(N_BANKS - 1));
      port_word[p] = WordW'((addr_i[p] >> BankBits) & ADDR_WIDTH'(CUT_N_WORDS - 1));
      port_row[p]  = RowW'((addr_i[p] >> (BankBits + WordBits)) & ADDR_WIDTH'(N_ROWS - 1));
    end
  end

  // Per-bank round-robin arbitration
  logic [PortW-1:0]   rr_q     [N_BANKS];
  logic [PortW-1:0]   rr_d     [N_BANKS];
  logic [PortW-1:0]   win_port [N_BANKS];
  logic [N_BANKS-1:0] win_valid;
  logic [N_PORTS-1:0] gnt;
  logic [PortSumW-1:0] idx_w;
  logic [PortW-1:0]    idx;

  always_comb begin
    gnt       = '0;
    win_valid = '0;
    idx_w     = '0;
    idx       = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      win_port[b] = '0;
      rr_d[b]     = rr_q[b];
      for (int k = 0; k < N_PORTS; k++) begin
        idx_w = {1'b0, rr_q[b]} + PortSumW'(k);
        if (idx_w >= PortSumW'(N_PORTS)) idx_w = idx_w - PortSumW'(N_PORTS);
        idx = idx_w[PortW-1:0];
        if (!win_valid[b] && req_i[idx] && (port_bank[idx] == BankW'(b))) begin
          win_valid[b] = 1'b1;
          win_port[b]  = idx;
        end
      end
      if (win_valid[b]) begin
        gnt[win_port[b]] = 1'b1;
        rr_d[b] = (win_port[b] == PortW'(N_PORTS - 1)) ? '0 : win_port[b] + 1'b1;
      end
    end
  end

  assign gnt_o = gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < N_BANKS; b++) rr_q[b] <= '0;
    end else begin
      for (int b = 0; b < N_BANKS; b++) rr_q[b] <= rr_d[b];
    end
  end

  // Steer each bank winner onto the single cut selected by its row field
  logic              cut_req   [N_BANKS][N_ROWS];
  logic              cut_we    [N_BANKS][N_ROWS];
  logic [WordW-1:0]  cut_addr  [N_BANKS][N_ROWS];
  logic [CUT_DW-1:0] cut_wdata [N_BANKS][N_ROWS];
  logic [BeW-1:0]    cut_be    [N_BANKS][N_ROWS];
  logic [CUT_DW-1:0] cut_rdata [N_BANKS][N_ROWS];

  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      for (int r = 0; r < N_ROWS; r++) begin
        cut_req[b][r]   = 1'b0;
        cut_we[b][r]    = 1'b0;
        cut_addr[b][r]  = '0;
        cut_wdata[b][r] = '0;
        cut_be[b][r]    = '0;
        if (win_valid[b] && (port_row[win_port[b]] == RowW'(r))) begin
          cut_req[b][r]   = 1'b1;
          cut_we[b][r]    = we_i[win_port[b]];
          cut_addr[b][r]  = port_word[win_port[b]];
          cut_wdata[b][r] = wdata_i[win_port[b]];
          cut_be[b][r]    = be_i[win_port[b]];
        end
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : gen_bank
    for (genvar r = 0; r < N_ROWS; r++) begin : gen_row
      logic [CUT_DW-1:0] mem_q [CUT_N_WORDS];
      logic [CUT_DW-1:0] rd_q  [SRAM_LATENCY];

      // Cut contents are deliberately not reset; the read stages shift every cycle so the
      // last stage lines up with the port pipeline that issued the read.
      always_ff @(posedge clk_i) begin
        if (cut_req[b][r]) begin
          if (cut_we[b][r]) begin
            for (int i = 0; i < BeW; i++) begin
              if (cut_be[b][r][i]) mem_q[cut_addr[b][r]][8*i +: 8] <= cut_wdata[b][r][8*i +: 8];
            end
          end else begin
            rd_q[0] <= mem_q[cut_addr[b][r]];
          end
        end
        for (int k = 1; k < SRAM_LATENCY; k++) rd_q[k] <= rd_q[k-1];
      end

      assign cut_rdata[b][r] = rd_q[SRAM_LATENCY-1];
    end
  end

  // Read-return pipeline per port
  for (genvar p = 0; p < N_PORTS; p++) begin : gen_port
    logic              vld_q  [SRAM_LATENCY];
    logic [BankW-1:0]  bank_q [SRAM_LATENCY];
    logic [RowW-1:0]   row_q  [SRAM_LATENCY];
    logic [CUT_DW-1:0] hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < SRAM_LATENCY; k++) begin
          vld_q[k]  <= 1'b0;
          bank_q[k] <= '0;
          row_q[k]  <= '0;
        end
        hold_q <= '0;
      end else begin
        vld_q[0]  <= gnt[p] & ~we_i[p];
        bank_q[0] <= port_bank[p];
        row_q[0]  <= port_row[p];
        for (int k = 1; k < SRAM_LATENCY; k++) begin
          vld_q[k]  <= vld_q[k-1];
          bank_q[k] <= bank_q[k-1];
          row_q[k]  <= row_q[k-1];
        end
        hold_q <= rdata_o[p];
      end
    end

    assign rvalid_o[p] = vld_q[SRAM_LATENCY-1];
    assign rdata_o[p]  = vld_q[SRAM_LATENCY-1] ?
                         cut_rdata[bank_q[SRAM_LATENCY-1]][row_q[SRAM_LATENCY-1]] : hold_q;
  end

  // Saturating count of refused requests
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]      n_conf, sum;

  always_comb begin
    n_conf = '0;
    for (int p = 0; p < N_PORTS; p++) n_conf = n_conf + SumW'(req_i[p] & ~gnt[p]);
    sum = {1'b0, cnt_q} + n_conf;
    if (conflict_clr_i) begin
      cnt_d = '0;
    end else if (sum[CNT_WIDTH]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_l2_banked_cut_array.sv
// Self-checking bench for l2_banked_cut_array: directed scenarios plus randomized traffic
// compared against a flat-memory reference model with per-bank rotating priority.
module tb_l2_banked_cut_array;
  localparam int NP  = 4;
  localparam int NB  = 4;
  localparam int NR  = 4;
  localparam int DW  = 64;
  localparam int NW  = 16;
  localparam int LAT = 3;
  localparam int AW  = 8;
  localparam int CW  = 4;

  logic                     clk, rst_n, clr;
  logic [NP-1:0]            req, gnt, we, rvalid;
  logic [NP-1:0][AW-1:0]    addr;
  logic [NP-1:0][DW-1:0]    wdata, rdata;
  logic [NP-1:0][DW/8-1:0]  be;
  logic [CW-1:0]            cnt;

  int checks, failures, cyc;

  typedef struct {
    int          port;
    int          due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rd_q[$];
  logic [DW-1:0] mem_m [256];
  int            rr_m [NB];
  int            cnt_m;
  logic [NP-1:0] exp_gnt, exp_rvalid;
  logic [NP-1:0][DW-1:0] exp_rdata;

  l2_banked_cut_array #(
    .N_PORTS(NP), .N_BANKS(NB), .N_ROWS(NR), .CUT_DW(DW), .CUT_N_WORDS(NW),
    .SRAM_LATENCY(LAT), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata),
    .conflict_cnt_o(cnt), .conflict_clr_i(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests and advance the reference model to its post-edge state.
  task automatic apply(input logic [NP-1:0] rq, input logic [NP-1:0] w,
                       input logic [NP-1:0][AW-1:0] a, input logic [NP-1:0][DW-1:0] d,
                       input logic [NP-1:0][DW/8-1:0] bmask, input logic cl);
    int  nconf;
    int  p;
    bit  found;
    rd_t e;
    req = rq; we = w; addr = a; wdata = d; be = bmask; clr = cl;
    #1;
    exp_gnt = '0;
    nconf   = 0;
    for (int bk = 0; bk < NB; bk++) begin
      found = 0;
      for (int k = 0; k < NP; k++) begin
        p = (rr_m[bk] + k) % NP;
        if (!found && rq[p] && ((int'(a[p]) % NB) == bk)) begin
          found      = 1;
          exp_gnt[p] = 1'b1;
          rr_m[bk]   = (p + 1) % NP;
        end
      end
    end
    for (int q = 0; q < NP; q++) begin
      if (exp_gnt[q] && !w[q]) begin
        e.port = q; e.due = cyc + LAT; e.data = mem_m[a[q]];
        rd_q.push_back(e);
      end
      if (rq[q] && !exp_gnt[q]) nconf++;
    end
    for (int q = 0; q < NP; q++) begin
      if (exp_gnt[q] && w[q]) begin
        for (int i = 0; i < DW / 8; i++) begin
          if (bmask[q][i]) mem_m[a[q]][8*i +: 8] = d[q][8*i +: 8];
        end
      end
    end
    cnt_m = cl ? 0 : ((cnt_m + nconf > 15) ? 15 : cnt_m + nconf);
  endtask

  task automatic idle();
    apply('0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic tick();
    rd_t keep[$];
    @(posedge clk);
    #1;
    cyc++;
    exp_rvalid = '0;
    foreach (rd_q[i]) begin
      if (rd_q[i].due == cyc) begin
        exp_rvalid[rd_q[i].port] = 1'b1;
        exp_rdata[rd_q[i].port]  = rd_q[i].data;
      end else begin
        keep.push_back(rd_q[i]);
      end
    end
    rd_q = keep;
  endtask

  task automatic model_reset();
    rd_q.delete();
    for (int b = 0; b < NB; b++) rr_m[b] = 0;
    cnt_m      = 0;
    exp_rvalid = '0;
  endtask

  task automatic do_reset();
    req = '0; we = '0; clr = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    checks++;
    if (gnt !== '0) begin failures++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
    checks++;
    if (rvalid !== '0) begin failures++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++;
    if (cnt !== '0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    tick();
    checks++;
    if (rvalid !== '0 || cnt !== '0) begin
      failures++; $display("FAIL reset_idle: rvalid %b cnt %0d expected 0/0", rvalid, cnt);
    end
  endtask

  // Fill every word with a known pattern: four distinct banks per cycle, all granted together.
  task automatic test_parallel_writes();
    logic [NP-1:0][AW-1:0] a;
    logic [NP-1:0][DW-1:0] d;
    for (int i = 0; i < 64; i++) begin
      for (int p = 0; p < NP; p++) begin
        a[p] = AW'(4 * i + p);
        d[p] = {8'hA5, 24'(a[p] * 7), 24'(a[p] * 13), a[p]};
      end
      apply('1, '1, a, d, '1, 1'b0);
      checks++;
      if (gnt !== 4'hF) begin failures++; $display("FAIL par_wr_gnt: got %b expected 1111", gnt); end
      tick();
    end
  endtask

  task automatic test_write_read();
    logic [NP-1:0][AW-1:0] a;
    logic [NP-1:0][DW-1:0] d;
    a = '0; d = '0;
    a[0] = 8'h05;
    d[0] = 64'hDEADBEEF_01234567;
    apply(4'b0001, 4'b0001, a, d, '1, 1'b0);
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL wr_gnt: got %b expected 0001", gnt); end
    tick();
    apply(4'b0001, 4'b0000, a, '0, '0, 1'b0);
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL rd_gnt: got %b expected 0001", gnt); end
    for (int j = 1; j <= LAT + 1; j++) begin
      tick();
      idle();
      checks++;
      if (rvalid[0] !== (j == LAT)) begin
        failures++; $display("FAIL rd_latency: tick %0d rvalid %b expected %b", j, rvalid[0], j == LAT);
      end
      if (j == LAT) begin
        checks++;
        if (rdata[0] !== 64'hDEADBEEF_01234567) begin
          failures++; $display("FAIL rd_data: got %h expected deadbeef01234567", rdata[0]);
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [NP-1:0][AW-1:0]   a;
    logic [NP-1:0][DW-1:0]   d;
    logic [NP-1:0][DW/8-1:0] bm;
    a = '0; d = '0; bm = '0;
    a[2] = 8'h09;
    d[2] = '1; bm[2] = 8'hFF;
    apply(4'b0100, 4'b0100, a, d, bm, 1'b0);
    tick();
    d[2] = '0; bm[2] = 8'h0F;
    apply(4'b0100, 4'b0100, a, d, bm, 1'b0);
    tick();
    apply(4'b0100, 4'b0000, a, '0, '0, 1'b0);
    for (int j = 1; j <= LAT; j++) begin
      tick();
      idle();
    end
    checks++;
    if (rvalid[2] !== 1'b1 || rdata[2] !== 64'hFFFFFFFF_00000000) begin
      failures++;
      $display("FAIL byte_enable: rvalid %b data %h expected 1 ffffffff00000000", rvalid[2], rdata[2]);
    end
  endtask

  task automatic test_conflict();
    logic [NP-1:0] seq [4];
    logic [NP-1:0][AW-1:0] a;
    logic [NP-1:0][DW-1:0] d;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b0010;
    do_reset();
    a = '0; a[0] = 8'h02; a[1] = 8'h06;
    for (int i = 0; i < 4; i++) begin
      d = '0; d[0] = 64'(i); d[1] = 64'(i + 100);
      apply(4'b0011, 4'b0011, a, d, '1, 1'b0);
      checks++;
      if (gnt !== seq[i]) begin
        failures++; $display("FAIL conflict_gnt[%0d]: got %b expected %b", i, gnt, seq[i]);
      end
      tick();
    end
    checks++;
    if (cnt !== 4'd4) begin failures++; $display("FAIL conflict_cnt: got %0d expected 4", cnt); end
    apply('0, '0, '0, '0, '0, 1'b1);
    tick();
    checks++;
    if (cnt !== 4'd0) begin failures++; $display("FAIL conflict_clr: got %0d expected 0", cnt); end
  endtask

  task automatic test_saturation();
    logic [NP-1:0][AW-1:0] a;
    logic [NP-1:0][DW-1:0] d;
    logic [CW-1:0] want;
    for (int p = 0; p < NP; p++) begin a[p] = AW'(4 * p); d[p] = {$urandom, $urandom}; end
    for (int j = 1; j <= 6; j++) begin
      apply('1, '1, a, d, '1, 1'b0);
      checks++;
      if (!$onehot(gnt)) begin failures++; $display("FAIL sat_gnt: got %b expected one-hot", gnt); end
      tick();
      want = (3 * j > 15) ? 4'd15 : CW'(3 * j);
      checks++;
      if (cnt !== want) begin failures++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", j, cnt, want); end
    end
    apply('1, '1, a, d, '1, 1'b1);
    tick();
    checks++;
    if (cnt !== 4'd0) begin failures++; $display("FAIL sat_clr_priority: got %0d expected 0", cnt); end
  endtask

  task automatic test_parallel_reads();
    logic [NP-1:0][AW-1:0] a;
    for (int p = 0; p < NP; p++) a[p] = AW'(p);
    apply('1, '0, a, '0, '0, 1'b0);
    checks++;
    if (gnt !== 4'hF) begin failures++; $display("FAIL par_rd_gnt: got %b expected 1111", gnt); end
    for (int j = 1; j <= LAT; j++) begin
      tick();
      idle();
      checks++;
      if (rvalid !== ((j == LAT) ? 4'hF : 4'h0)) begin
        failures++; $display("FAIL par_rd_rvalid: tick %0d got %b", j, rvalid);
      end
    end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (rdata[p] !== exp_rdata[p]) begin
        failures++; $display("FAIL par_rd_data[%0d]: got %h expected %h", p, rdata[p], exp_rdata[p]);
      end
    end
  endtask

  // Same bank and word offset across all four rows; only the row field differs.
  task automatic test_rows();
    logic [DW-1:0] vals [NR];
    logic [NP-1:0][AW-1:0] a;
    logic [NP-1:0][DW-1:0] d;
    for (int r = 0; r < NR; r++) begin
      vals[r] = {16'hB0B0 + 16'(r), 32'h0, 16'(r * 3 + 1)};
      a = '0; d = '0;
      a[0] = AW'(r * 64 + 3 * 4 + 1);
      d[0] = vals[r];
      apply(4'b0001, 4'b0001, a, d, '1, 1'b0);
      tick();
    end
    for (int j = 1; j <= 7; j++) begin
      if (j <= NR) begin
        a = '0; a[3] = AW'((j - 1) * 64 + 3 * 4 + 1);
        apply(4'b1000, 4'b0000, a, '0, '0, 1'b0);
      end else begin
        idle();
      end
      tick();
      checks++;
      if (rvalid[3] !== (j >= LAT && j < LAT + NR)) begin
        failures++; $display("FAIL rows_rvalid: tick %0d got %b", j, rvalid[3]);
      end else if (j >= LAT && j < LAT + NR) begin
        checks++;
        if (rdata[3] !== vals[j - LAT]) begin
          failures++; $display("FAIL rows_data[%0d]: got %h expected %h", j - LAT, rdata[3], vals[j - LAT]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [NP-1:0][AW-1:0] a;
    logic [DW-1:0] want;
    a = '0; a[0] = 8'h09; a[1] = 8'h45;
    want = mem_m[8'h45];
    apply(4'b0011, 4'b0000, a, '0, '0, 1'b0);
    checks++;
    if (gnt !== exp_gnt) begin failures++; $display("FAIL mid_gnt: got %b expected %b", gnt, exp_gnt); end
    tick();
    req = '0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 1; j <= LAT + 2; j++) begin
      idle();
      tick();
      checks++;
      if (rvalid !== '0 || cnt !== '0) begin
        failures++; $display("FAIL mid_flush: tick %0d rvalid %b cnt %0d expected 0/0", j, rvalid, cnt);
      end
    end
    a = '0; a[1] = 8'h45;
    apply(4'b0010, 4'b0000, a, '0, '0, 1'b0);
    for (int j = 1; j <= LAT; j++) begin
      tick();
      idle();
    end
    checks++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== want) begin
      failures++; $display("FAIL mid_reread: rvalid %b data %h expected 1 %h", rvalid[1], rdata[1], want);
    end
  endtask

  task automatic test_random();
    logic [NP-1:0][AW-1:0]   a;
    logic [NP-1:0][DW-1:0]   d;
    logic [NP-1:0][DW/8-1:0] bm;
    for (int j = 0; j < LAT; j++) begin idle(); tick(); end
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        a[p]  = AW'($urandom_range(0, 255));
        d[p]  = {$urandom, $urandom};
        bm[p] = 8'($urandom);
      end
      apply(4'($urandom), 4'($urandom), a, d, bm, $urandom_range(0, 7) == 0);
      checks++;
      if (gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt[%0d]: got %b expected %b", n, gnt, exp_gnt); end
      tick();
      checks++;
      if (rvalid !== exp_rvalid) begin
        failures++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", n, rvalid, exp_rvalid);
      end
      for (int p = 0; p < NP; p++) begin
        if (exp_rvalid[p]) begin
          checks++;
          if (rdata[p] !== exp_rdata[p]) begin
            failures++; $display("FAIL rand_rdata[%0d][%0d]: got %h expected %h", n, p, rdata[p], exp_rdata[p]);
          end
        end
      end
      checks++;
      if (cnt !== CW'(cnt_m)) begin failures++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, cnt, cnt_m); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; be = '0; clr = 1'b0;
    exp_rdata = '0;
    model_reset();
    test_reset();
    test_parallel_writes();
    test_write_read();
    test_byte_enable();
    test_conflict();
    test_saturation();
    test_parallel_reads();
    test_rows();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_banked_cut_array.md
# l2_banked_cut_array

Multi-port, word-interleaved SRAM cut array for the L2 subsystem. It replaces a fixed two-port, single-cycle-latency cut wrapper with a generalised back end: any number of request ports, any number of column banks and serial cut rows, and any SRAM latency ≥1. Per-bank round-robin arbitration and a per-port read-return pipeline keep row selection correct at every latency. It sits below the AXI-to-memory protocol converters and instantiates the `sram` cut macros.

## Interface
- `N_PORTS`, 2: number of requester ports (≥1).
- `N_BANKS`, 4: column banks, word-interleaved; power of 2, ≥1.
- `N_ROWS`, 2: serial cuts per bank; power of 2, ≥1.
- `CUT_DW`, 64: cut data width [bit]; power of 2, ≥8.
- `CUT_N_WORDS`, 16384: words per cut; power of 2.
- `SRAM_LATENCY`, 1: cut read latency [cycles], ≥1.
- `ADDR_WIDTH`, derived: $clog2(N_BANKS*N_ROWS*CUT_N_WORDS); word address width.
- `CNT_WIDTH`, 32: conflict counter width.

Ports:
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  N_PORTS  request valid per port.
- `gnt_o`  out  N_PORTS  grant, combinational in the same cycle as req_i.
- `addr_i`  in  N_PORTS×ADDR_WIDTH  word address.
- `we_i`  in  N_PORTS  1 = write, 0 = read.
- `wdata_i`  in  N_PORTS×CUT_DW  write data.
- `be_i`  in  N_PORTS×CUT_DW/8  byte enables (writes only).
- `rvalid_o`  out  N_PORTS  read data valid.
- `rdata_o`  out  N_PORTS×CUT_DW  read data.
- `conflict_cnt_o`  out  CNT_WIDTH  saturating count of refused requests.
- `conflict_clr_i`  in  1  synchronous clear of conflict_cnt_o.

## Operation
- Address split, LSB first: bank = addr[log2(N_BANKS)-1:0]; word-in-cut = next log2(CUT_N_WORDS) bits; row = top log2(N_ROWS) bits. Fields of width 0 are absent, and index 0 is used for them.
- Arbitration per bank: the candidate set is the ports with req_i=1 that target that bank. Search starts at the bank's pointer rr_q[b] and proceeds in ascending index order with wrap. The first candidate found is granted.
- On a grant to port p, rr_q[b] ← (p+1) mod N_PORTS. If the bank issues no grant, the pointer holds. All pointers reset to 0.
- A granted request drives exactly one cut, [bank][row]: req=1, with we, word address, wdata and be from the winner. All other cuts see req=0.
- Write: the cut updates at the grant edge. No response is returned.
- Read: the port pipeline stage 0 captures {valid=1, bank, row}. The pipeline is a shift register of depth SRAM_LATENCY per port. On the final stage, rvalid_o[p]=1 and rdata_o[p]=cut_rdata[bank][row] of the captured indices.
- When rvalid_o[p]=0, rdata_o[p] holds its last value. It is don't-care for verification.
- Conflict counter: each cycle, add the number of ports with req_i=1 and gnt_o=0. The counter saturates at 2^CNT_WIDTH−1. conflict_clr_i=1 forces 0 and takes priority over the add.
- Ungranted requests are not stored. The requester must hold req_i until granted.

## Timing
- Grant: 0 cycles, combinational from req_i/addr_i and rr_q.
- Read data: rvalid_o exactly SRAM_LATENCY cycles after the grant edge.
  - Throughput is one read per port per cycle, pipelined.
  - A port may have SRAM_LATENCY reads in flight, each returned in order.
- Read after write: a read granted on any cycle after a write's grant returns the written bytes. Unwritten bytes are preserved.
- Reset values: rvalid_o=0, conflict_cnt_o=0, rr_q=0, all pipeline valids=0.
  - Reset mid-operation discards all in-flight reads, so no rvalid_o follows.
  - SRAM contents are not reset.
- Different banks are granted in parallel. N_PORTS requests to N_PORTS distinct banks are all granted in the same cycle.

## Test plan
- Single port, SRAM_LATENCY=1: write 0xDEADBEEF_01234567 at addr 0x5, then read addr 0x5 → gnt_o=1 on both; rvalid_o[0]=1 one cycle after the read grant with rdata 0xDEADBEEF_01234567.
- Byte enables: write all-ones, then write 0x0 with be=0x0F, then read → 0xFFFFFFFF_00000000.
- Bank conflict: ports 0 and 1 hold a request to bank 2 for 4 cycles from reset.
  - Grant sequence p0, p1, p0, p1 is required.
  - conflict_cnt_o=4 afterwards; conflict_clr_i → 0 next cycle.
- Parallel banks, N_PORTS=4: ports read addrs 0,1,2,3 in one cycle → all gnt_o=1; all rvalid_o=1 together after SRAM_LATENCY.
- Row selection, SRAM_LATENCY=3, N_ROWS=4: back-to-back reads on one port to row 0,1,2,3 of the same bank and word offset, preloaded with distinct values.
  - Required: four consecutive rvalid cycles returning the values in order.
- Reset mid-flight, SRAM_LATENCY=3: assert rst_ni=0 one cycle after a read grant → no rvalid_o ever; conflict_cnt_o=0; memory contents intact on re-read.
